hybrid_combine_fxp: RTL and testbench

- Parametrised successor to the final combine stage of the hybrid control-bounded filter. It takes the lookahead (FIR) partial result and the lookback (recursion) partial result per downsampled sample, and runs on one clock with stream handshakes instead of a derived divided clock.
- Each path arrives independently and is aligned by a per-path FIFO. Pairs are added, rounded, saturated and formatted to a configurable output width.
- Supports multiple time-interleaved channels, a warm-up discard and output backpressure.

---
 rtl/hybrid_combine_fxp.sv | 194 +++++++++++++++++++
 tb/tb_hybrid_combine_fxp.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_combine_fxp.sv
// Final combine stage of the hybrid control-bounded filter: aligns the lookahead and
// lookback partial results per channel, then adds, rounds, saturates and formats them.

module hybrid_combine_fxp_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         push,
    output logic         ready,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         nempty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          wr;

    // ready looks at the occupancy only, never at a same-cycle pop
    assign ready  = !rst && (count < (AW+1)'(DEPTH));
    assign wr     = push && ready;
    assign head   = mem[rptr];
    assign nempty = (count != '0);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
endmodule

module hybrid_combine_fxp #(
    parameter  int N_CH        = 1,
    parameter  int N_INT       = 9,
    parameter  int N_MANT      = 15,
    parameter  int OUT_WIDTH   = 14,
    parameter  int ALIGN_DEPTH = 4,
    parameter  int WARMUP      = 0,
    parameter  int OFFSET_BIN  = 1,
    localparam int CW          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MANT:0]         ahead_data,
    input  logic                    ahead_valid,
    output logic                    ahead_ready,
    input  logic [N_INT+N_MANT:0]   back_data,
    input  logic                    back_valid,
    output logic                    back_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic [CW-1:0]           out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_pulse,
    output logic                    sat_sticky,
    input  logic                    clr_sat
);
    localparam int AWD      = N_MANT + 1;
    localparam int BWD      = N_INT + N_MANT + 1;
    localparam int SW       = N_INT + N_MANT + 2;
    localparam int R        = N_MANT - (OUT_WIDTH - 1);
    localparam int WU_TOTAL = WARMUP * N_CH;
    localparam int WUW      = (WU_TOTAL > 0) ? $clog2(WU_TOTAL + 1) : 1;

    localparam logic signed [SW:0] RHALF = (SW+1)'((2 ** R) / 2);
    localparam logic signed [SW:0] MAXV  = (SW+1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW:0] MINV  = (SW+1)'(-(2 ** (OUT_WIDTH - 1)));

    logic [AWD-1:0] a_head;
    logic [BWD-1:0] b_head;
    logic           a_ne;
    logic           b_ne;
    logic           pop;
    logic           s1_adv;
    logic           out_adv;
    logic [SW-1:0]  sum;

    logic           s1_valid;
    logic           s1_keep;
    logic [SW-1:0]  s1_sum;
    logic [CW-1:0]  s1_ch;
    logic [CW-1:0]  ch_cnt;
    logic [WUW-1:0] wu_cnt;
    logic           wu_done;

    logic signed [SW:0]   ext;
    logic signed [SW:0]   shifted;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_WIDTH-1:0] clip;
    logic [OUT_WIDTH-1:0] fmt;
    logic                 load;

    hybrid_combine_fxp_fifo #(.W(AWD), .DEPTH(ALIGN_DEPTH)) u_ahead_fifo (
        .clk    (clk),
        .rst    (rst),
        .din    (ahead_data),
        .push   (ahead_valid),
        .ready  (ahead_ready),
        .pop    (pop),
        .head   (a_head),
        .nempty (a_ne)
    );

    hybrid_combine_fxp_fifo #(.W(BWD), .DEPTH(ALIGN_DEPTH)) u_back_fifo (
        .clk    (clk),
        .rst    (rst),
        .din    (back_data),
        .push   (back_valid),
        .ready  (back_ready),
        .pop    (pop),
        .head   (b_head),
        .nempty (b_ne)
    );

    assign out_adv = !out_valid || out_ready;
    assign s1_adv  = !s1_valid || out_adv;
    assign pop     = a_ne && b_ne && s1_adv;
    assign wu_done = (wu_cnt == WUW'(WU_TOTAL));

    // one guard bit above the lookback range, so the sum cannot overflow
    assign sum = {{(SW-AWD){a_head[AWD-1]}}, a_head} + {{(SW-BWD){b_head[BWD-1]}}, b_head};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_keep  <= 1'b0;
            s1_sum   <= '0;
            s1_ch    <= '0;
            ch_cnt   <= '0;
            wu_cnt   <= '0;
        end else if (s1_adv) begin
            s1_valid <= pop;
            if (pop) begin
                s1_sum  <= sum;
                s1_ch   <= ch_cnt;
                s1_keep <= wu_done;
                ch_cnt  <= (ch_cnt == CW'(N_CH - 1)) ? '0 : ch_cnt + 1'b1;
                if (!wu_done) wu_cnt <= wu_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        ext     = $signed({s1_sum[SW-1], s1_sum}) + RHALF;
        shifted = ext >>> R;
        sat_hi  = shifted > MAXV;
        sat_lo  = shifted < MINV;
        if (sat_hi)      clip = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (sat_lo) clip = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else             clip = shifted[OUT_WIDTH-1:0];
        fmt = (OFFSET_BIN != 0) ? {~clip[OUT_WIDTH-1], clip[OUT_WIDTH-2:0]} : clip;
    end

    // warm-up samples still drain through stage 1 but are never presented
    assign load = out_adv && s1_valid && s1_keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            sat_pulse  <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            if (out_adv) begin
                out_valid <= load;
                sat_pulse <= load && (sat_hi || sat_lo);
                if (load) begin
                    out_data <= fmt;
                    out_ch   <= s1_ch;
                end
            end
            if (load && (sat_hi || sat_lo)) sat_sticky <= 1'b1;
            else if (clr_sat)               sat_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hybrid_combine_fxp.sv
// Scoreboard bench for hybrid_combine_fxp: random and directed pairs are modelled
// with plain integer arithmetic and checked by an independent output monitor.

module tb_hybrid_combine_fxp;
    localparam int N_CH        = 2;
    localparam int N_INT       = 9;
    localparam int N_MANT      = 15;
    localparam int OUT_WIDTH   = 14;
    localparam int ALIGN_DEPTH = 4;
    localparam int WARMUP      = 2;
    localparam int OFFSET_BIN  = 1;
    localparam int AWD         = N_MANT + 1;
    localparam int BWD         = N_INT + N_MANT + 1;
    localparam int R           = N_MANT - (OUT_WIDTH - 1);
    localparam int CW          = 1;
    localparam int NRAND       = 200;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [AWD-1:0]       ahead_data = '0;
    logic                 ahead_valid = 1'b0;
    logic                 ahead_ready;
    logic [BWD-1:0]       back_data = '0;
    logic                 back_valid = 1'b0;
    logic                 back_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 sat_pulse;
    logic                 sat_sticky;
    logic                 clr_sat = 1'b0;

    always #5 clk = ~clk;

    hybrid_combine_fxp #(
        .N_CH(N_CH), .N_INT(N_INT), .N_MANT(N_MANT), .OUT_WIDTH(OUT_WIDTH),
        .ALIGN_DEPTH(ALIGN_DEPTH), .WARMUP(WARMUP), .OFFSET_BIN(OFFSET_BIN)
    ) dut (
        .clk(clk), .rst(rst),
        .ahead_data(ahead_data), .ahead_valid(ahead_valid), .ahead_ready(ahead_ready),
        .back_data(back_data), .back_valid(back_valid), .back_ready(back_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .sat_pulse(sat_pulse), .sat_sticky(sat_sticky), .clr_sat(clr_sat)
    );

    typedef struct {
        logic [OUT_WIDTH-1:0] d;
        logic [CW-1:0]        ch;
        logic                 s;
    } exp_t;

    logic [AWD-1:0] aq[$];
    logic [BWD-1:0] bq[$];
    exp_t           eq[$];
    int             n_pairs = 0;
    int             vectors = 0;
    int             miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired, got no event, expected one (t=%0t)", name, $time);
    endtask

    function automatic longint fdiv(input longint x, input longint m);
        if (x >= 0) return x / m;
        return -((-x + m - 1) / m);
    endfunction

    // Real value = word / 2^N_MANT; output LSB is 2^R input LSBs; round half up, clip, format.
    function automatic exp_t model(input logic [AWD-1:0] a, input logic [BWD-1:0] b, input int k);
        exp_t   e;
        longint sum, q, hi, lo, step;
        step = longint'(1) << R;
        hi   = (longint'(1) << (OUT_WIDTH - 1)) - 1;
        lo   = -(longint'(1) << (OUT_WIDTH - 1));
        sum  = longint'($signed(a)) + longint'($signed(b));
        q    = fdiv(sum + step / 2, step);
        e.s  = 1'b0;
        if (q > hi) begin
            q = hi;
            e.s = 1'b1;
        end else if (q < lo) begin
            q = lo;
            e.s = 1'b1;
        end
        e.d = OUT_WIDTH'(q);
        if (OFFSET_BIN != 0) e.d[OUT_WIDTH-1] = ~e.d[OUT_WIDTH-1];
        e.ch = CW'(k % N_CH);
        return e;
    endfunction

    function automatic logic [AWD-1:0] rand_a();
        return AWD'($urandom);
    endfunction

    function automatic logic [BWD-1:0] rand_b();
        logic [BWD-1:0] b;
        b = BWD'($urandom);
        if ($urandom_range(2) != 0) b = BWD'($signed(b[15:0]));
        return b;
    endfunction

    // acceptance recorder: pairs words by arrival order and queues expected beats
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                aq.delete();
                bq.delete();
                eq.delete();
                n_pairs = 0;
            end else begin
                if (ahead_valid && ahead_ready) aq.push_back(ahead_data);
                if (back_valid && back_ready)   bq.push_back(back_data);
                while (aq.size() > 0 && bq.size() > 0) begin
                    e = model(aq.pop_front(), bq.pop_front(), n_pairs);
                    if (n_pairs >= WARMUP * N_CH) eq.push_back(e);
                    n_pairs++;
                end
            end
        end
    end

    // output monitor
    initial begin
        exp_t                 e;
        logic                 pstall = 1'b0;
        logic [OUT_WIDTH-1:0] pd = '0;
        logic [CW-1:0]        pch = '0;
        logic                 ps = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, pd);
                    check("hold_ch", out_ch, pch);
                    check("hold_sat", sat_pulse, ps);
                end
                if (out_valid && out_ready) begin
                    if (eq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_out: got out_data 0x%0h, expected no beat (t=%0t)", out_data, $time);
                    end else begin
                        e = eq.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_ch", out_ch, e.ch);
                        check("sat_pulse", sat_pulse, e.s);
                    end
                end
                pstall = out_valid && !out_ready;
                pd     = out_data;
                pch    = out_ch;
                ps     = sat_pulse;
            end
        end
    end

    task automatic push_pair(input logic [AWD-1:0] a, input logic [BWD-1:0] b);
        int n = 0;
        bit done = 0;
        ahead_data = a;
        back_data = b;
        ahead_valid = 1'b1;
        back_valid = 1'b1;
        while (!done && n < 20) begin
            @(posedge clk);
            done = ahead_ready && back_ready;
            #1;
            n++;
        end
        ahead_valid = 1'b0;
        back_valid = 1'b0;
        if (!done) timeout("push_pair");
    endtask

    // returns at the negedge on which out_valid is first seen; lat counts cycles after acceptance
    task automatic send_wait(input logic [AWD-1:0] a, input logic [BWD-1:0] b, output int lat);
        push_pair(a, b);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic round_case(input string name, input logic [AWD-1:0] a, input logic [BWD-1:0] b,
                              input logic [OUT_WIDTH-1:0] exp_d, input logic exp_s);
        int lat;
        send_wait(a, b, lat);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_sat"}, sat_pulse, exp_s);
        @(posedge clk);
        #1;
    endtask

    // ahead leads back by 3 cycles while the output is held off for 12 cycles
    task automatic run_stall(output int ia, output int ib, output int first_drop);
        bit acc_a, acc_b;
        ia = 0;
        ib = 0;
        first_drop = -1;
        out_ready = 1'b0;
        ahead_data = rand_a();
        back_data = rand_b();
        ahead_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            back_valid = (c >= 3);
            @(posedge clk);
            acc_a = ahead_valid && ahead_ready;
            acc_b = back_valid && back_ready;
            if (!ahead_ready && first_drop < 0) first_drop = c;
            #1;
            if (acc_a) begin ia++; ahead_data = rand_a(); end
            if (acc_b) begin ib++; back_data = rand_b(); end
        end
        ahead_valid = 1'b0;
        back_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((eq.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (eq.size() != 0) timeout(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, ia, ib, fd, seen, na, nb;
        bit acc_a, acc_b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_sat_pulse", sat_pulse, 0);
        check("rst_sat_sticky", sat_sticky, 0);
        check("rst_ahead_ready", ahead_ready, 0);
        check("rst_back_ready", back_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_ahead_ready", ahead_ready, 1);
        check("rel_back_ready", back_ready, 1);
        @(posedge clk);
        #1;

        // warm-up: four discarded pairs, then the fifth is presented on channel 0
        for (int i = 0; i < WARMUP * N_CH; i++) push_pair(rand_a(), rand_b());
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("warmup_quiet", seen, 0);
        @(posedge clk);
        #1;
        send_wait(16'h2000, 25'h0002000, lat);
        check("latency", lat, 3);
        check("half_data", out_data, 14'h3000);
        check("half_sat", sat_pulse, 0);
        check("first_ch", out_ch, 0);
        @(posedge clk);
        #1;

        // saturation and sticky flag
        send_wait(16'h0000, 25'h0010000, lat);
        check("satp_data", out_data, 14'h3FFF);
        check("satp_pulse", sat_pulse, 1);
        check("satp_sticky", sat_sticky, 1);
        @(posedge clk);
        #1;
        send_wait(16'h0000, 25'h1FE8000, lat);
        check("satn_data", out_data, 14'h0000);
        check("satn_pulse", sat_pulse, 1);
        @(posedge clk);
        #1 clr_sat = 1'b1;
        @(posedge clk);
        #1 clr_sat = 1'b0;
        @(negedge clk);
        check("clr_sticky", sat_sticky, 0);
        @(posedge clk);
        #1 clr_sat = 1'b1;
        send_wait(16'h0000, 25'h0010000, lat);
        check("clr_vs_set_sticky", sat_sticky, 1);
        clr_sat = 1'b0;
        @(posedge clk);
        #1;

        // rounding boundaries (offset-binary view of +1, 0, 0, -1, clipped +1.0)
        round_case("rnd_p2", 16'h0002, 25'h0000000, 14'h2001, 1'b0);
        round_case("rnd_p1", 16'h0001, 25'h0000000, 14'h2000, 1'b0);
        round_case("rnd_m2", 16'hFFFE, 25'h0000000, 14'h2000, 1'b0);
        round_case("rnd_m3", 16'hFFFD, 25'h0000000, 14'h1FFF, 1'b0);
        round_case("rnd_ovf", 16'h0001, 25'h0007FFF, 14'h3FFF, 1'b1);

        // skew plus backpressure
        run_stall(ia, ib, fd);
        @(negedge clk);
        check("stall_first_drop", fd, 4);
        check("stall_ahead_cnt", ia, 6);
        check("stall_back_cnt", ib, 6);
        check("stall_ahead_ready", ahead_ready, 0);
        check("stall_back_ready", back_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("stall_drain");

        // random traffic with random backpressure
        na = 0;
        nb = 0;
        for (int c = 0; c < 4000 && (na < NRAND || nb < NRAND); c++) begin
            if (!ahead_valid && na < NRAND && $urandom_range(3) != 0) begin
                ahead_valid = 1'b1;
                ahead_data = rand_a();
            end
            if (!back_valid && nb < NRAND && $urandom_range(3) != 0) begin
                back_valid = 1'b1;
                back_data = rand_b();
            end
            out_ready = ($urandom_range(3) != 0);
            @(posedge clk);
            acc_a = ahead_valid && ahead_ready;
            acc_b = back_valid && back_ready;
            #1;
            if (acc_a) begin na++; ahead_valid = 1'b0; end
            if (acc_b) begin nb++; back_valid = 1'b0; end
        end
        ahead_valid = 1'b0;
        back_valid = 1'b0;
        out_ready = 1'b1;
        check("rand_ahead_sent", na, NRAND);
        check("rand_back_sent", nb, NRAND);
        wait_drain("rand_drain");

        // reset with FIFOs and pipeline full
        run_stall(ia, ib, fd);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_ahead_ready", ahead_ready, 0);
        check("mrst_back_ready", back_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_sat_sticky", sat_sticky, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mrst_rel_ahead_ready", ahead_ready, 1);
        check("mrst_rel_back_ready", back_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < WARMUP * N_CH; i++) push_pair(rand_a(), rand_b());
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mrst_warmup_quiet", seen, 0);
        @(posedge clk);
        #1;
        send_wait(rand_a(), rand_b(), lat);
        check("mrst_latency", lat, 3);
        check("mrst_first_ch", out_ch, 0);
        @(posedge clk);
        #1;
        wait_drain("final_drain");
        check("final_queue_empty", eq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
